// File: rtl/bist_stack_pkg.sv
// bist_stack_pkg: shared stacked-code definitions for the 6:3 counter BIST (decoder, comparator, stacker model).
package bist_stack_pkg;
  localparam int STACK_W    = 3;
  localparam int NUM_STACKS = 2;
  localparam int STK_CNT_W  = $clog2(STACK_W + 1);
  localparam logic [STACK_W-1:0] STK_0 = 3'b000;
  localparam logic [STACK_W-1:0] STK_1 = 3'b001;
  localparam logic [STACK_W-1:0] STK_2 = 3'b011;
  localparam logic [STACK_W-1:0] STK_3 = 3'b111;
  function automatic logic [STK_CNT_W-1:0] stack_popcount(input logic [STACK_W-1:0] s);
    logic [STK_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STACK_W; i++) c = c + STK_CNT_W'(s[i]);
    return c;
  endfunction
  // A stack is legal when no set bit sits above a clear bit.
  function automatic logic stack_is_legal(input logic [STACK_W-1:0] s);
    return ~|(s[STACK_W-1:1] & ~s[STACK_W-2:0]);
  endfunction
endpackage

// File: rtl/stack_code_check.sv
// stack_code_check: one stacked code -> popcount and illegal (non-thermometer) flag, combinational.
module stack_code_check
  import bist_stack_pkg::*;
#(
  parameter int W  = STACK_W,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  stack,
  output logic [CW-1:0] cnt,
  output logic          ill
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(stack[i]);
  end
  assign ill = |(stack[W-1:1] & ~stack[W-2:0]);
endmodule

// File: rtl/stack_code_decoder.sv
// stack_code_decoder: 2-stage stacked-code to binary count decoder with legality check, valid/ready stream.
module stack_code_decoder #(
  parameter int STACK_W    = bist_stack_pkg::STACK_W,
  parameter int NUM_STACKS = bist_stack_pkg::NUM_STACKS,
  parameter int CNT_W      = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_STACKS*STACK_W-1:0] in_stacks,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_err,
  output logic                          err_sticky,
  input  logic                          clear
`ifdef STACK_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0]        err_count
`endif
);
  localparam int CW = $clog2(STACK_W + 1);
  logic                  s1_valid, s2_valid, s1_adv, err_fire;
  logic [CW-1:0]         cnt [NUM_STACKS];
  logic [CW-1:0]         s1_cnt [NUM_STACKS];
  logic [NUM_STACKS-1:0] ill, s1_ill;
  logic [CNT_W-1:0]      sum;
  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;
  assign err_fire  = out_valid && out_ready && out_err;
  for (genvar k = 0; k < NUM_STACKS; k++) begin : g_chk
    stack_code_check #(.W(STACK_W), .CW(CW)) u_chk (
      .stack(in_stacks[k*STACK_W +: STACK_W]),
      .cnt  (cnt[k]),
      .ill  (ill[k])
    );
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_STACKS; k++) sum = sum + CNT_W'(s1_cnt[k]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_cnt    <= '{default: '0};
      s1_ill    <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_cnt <= cnt;
        s1_ill <= ill;
      end
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_adv && s1_valid) begin
        out_count <= sum;
        out_err   <= |s1_ill;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) err_sticky <= 1'b0;
    else if (err_fire) err_sticky <= 1'b1;
  end
`ifdef STACK_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clear) err_count <= '0;
    else if (err_fire && !(&err_count)) err_count <= err_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_stack_code_decoder.sv
// tb_stack_code_decoder: scoreboard bench for stack_code_decoder; reference model works on whole beats.
module tb_stack_code_decoder;
  typedef struct { int cnt; bit err; } exp_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [5:0] in_stacks = '0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [2:0] out_count;
  logic       out_err;
  logic       err_sticky;
  logic       clear = 0;
`ifdef STACK_ERR_CNT_EN
  logic [1:0] err_count;
`endif
  exp_t q[$];
  int   n_chk = 0, n_pass = 0, n_out = 0, cyc = 0, last_cyc = 0;
  bit   mon_en = 0, exp_sticky = 0;
  int   exp_errcnt = 0;
  logic [2:0] legal [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
  stack_code_decoder #(.ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_stacks(in_stacks),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_err(out_err),
    .err_sticky(err_sticky), .clear(clear)
`ifdef STACK_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction
  function automatic exp_t model(input logic [5:0] s);
    exp_t e;
    logic [2:0] st;
    e.cnt = $countones(s);
    e.err = 0;
    for (int k = 0; k < 2; k++) begin
      st = s[k*3 +: 3];
      if (!(st inside {3'b000, 3'b001, 3'b011, 3'b111})) e.err = 1;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("err_sticky", int'(err_sticky), int'(exp_sticky));
`ifdef STACK_ERR_CNT_EN
      chk("err_count", int'(err_count), exp_errcnt);
`endif
      if (!rst_n) begin
        q.delete();
        exp_sticky = 0;
        exp_errcnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          last_cyc = cyc;
          if (q.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("out_count", int'(out_count), e.cnt);
            chk("out_err", int'(out_err), int'(e.err));
            if (e.err) begin
              exp_sticky = 1;
              if (exp_errcnt < 3) exp_errcnt++;
            end
          end
        end
        if (clear) begin
          exp_sticky = 0;
          exp_errcnt = 0;
        end
      end
    end
  end
  task automatic drive(input logic [5:0] s, input bit v, input bit r, input bit c, output bit acc);
    @(negedge clk);
    in_stacks = s; in_valid = v; out_ready = r; clear = c;
    #2;
    acc = v && in_ready && rst_n;
    if (acc) q.push_back(model(s));
  endtask
  task automatic send(input logic [5:0] s, input bit r);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 20) begin
      drive(s, 1, r, 0, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    bit acc;
    repeat (n) drive('0, 0, 1, 0, acc);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit acc, saw_low;
    int c0, start, n_acc, i;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_err_sticky", int'(err_sticky), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    mon_en = 1;
    @(negedge clk); rst_n = 1;
    idle(2);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) send({legal[b], legal[a]}, 1);
    idle(4);
    chk("legal_no_sticky", int'(err_sticky), 0);
    send({3'b010, 3'b111}, 1);
    send({3'b101, 3'b000}, 1);
    idle(4);
    chk("sticky_after_ill", int'(err_sticky), 1);
    drive('0, 0, 1, 1, acc);
    idle(1);
    chk("sticky_cleared", int'(err_sticky), 0);
    drive({3'b011, 3'b001}, 1, 1, 0, acc);
    chk("lat_accept", int'(acc), 1);
    drive('0, 0, 1, 0, acc);
    chk("lat_c1_valid", int'(out_valid), 0);
    drive('0, 0, 1, 0, acc);
    chk("lat_c2_valid", int'(out_valid), 1);
    idle(3);
    start = n_out; n_acc = 0; c0 = 0;
    for (int k = 0; k < 64; k++) begin
      drive({legal[$urandom_range(0, 3)], legal[$urandom_range(0, 3)]}, 1, 1, 0, acc);
      if (k == 0) c0 = cyc;
      if (acc) n_acc++;
    end
    i = 0;
    while (n_out < start + 64 && i < 20) begin idle(1); i++; end
    chk("tput_accepted", n_acc, 64);
    chk("tput_outputs", n_out - start, 64);
    chk("tput_cycles", last_cyc - c0 + 1, 66);
    idle(3);
    n_acc = 0; i = 0; saw_low = 0; start = n_out;
    while (i < 40 && (n_acc < 8 || q.size() != 0)) begin
      logic [5:0] s;
      s = {legal[$urandom_range(0, 3)], 3'b010 ^ 3'($urandom_range(0, 7))};
      drive(s, n_acc < 8, !(i >= 3 && i <= 6), 0, acc);
      if (acc) n_acc++;
      if (n_acc < 8 && !in_ready) saw_low = 1;
      i++;
    end
    chk("bp_in_ready_dropped", int'(saw_low), 1);
    chk("bp_outputs", n_out - start, 8);
    drive('0, 0, 1, 1, acc);
    send({3'b000, 3'b010}, 1);
    idle(4);
    chk("sticky_set_again", int'(err_sticky), 1);
    send({3'b100, 3'b001}, 1);
    drive('0, 0, 1, 0, acc);
    drive('0, 0, 1, 1, acc);
    chk("clear_edge_valid", int'(out_valid), 1);
    idle(1);
    chk("clear_wins", int'(err_sticky), 0);
`ifdef STACK_ERR_CNT_EN
    for (int k = 0; k < 5; k++) send({3'b110, 3'b011}, 1);
    idle(4);
    chk("errcnt_saturated", int'(err_count), 3);
    send({3'b010, 3'b000}, 1);
    drive('0, 0, 1, 0, acc);
    drive('0, 0, 1, 1, acc);
    idle(1);
    chk("errcnt_clear_wins", int'(err_count), 0);
`endif
    drive({3'b010, 3'b010}, 1, 1, 0, acc);
    drive({3'b101, 3'b101}, 1, 1, 0, acc);
    @(negedge clk); rst_n = 0; in_valid = 0; #2;
    @(negedge clk); rst_n = 1; #2;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sticky", int'(err_sticky), 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("midrst_no_stale", int'(out_valid), 0);
    end
    for (int k = 0; k < 300; k++)
      drive(6'($urandom), $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc);
    idle(6);
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
